rr_mux_arb: RTL
===============

# rr_mux_arb

Parametrised N-channel registered multiplexer with arbitration and a valid/ready handshake. It is the sequential successor to the 4-to-1 gate-level mux: N_CH input channels of WIDTH bits each compete for one output register. The winner is chosen by round-robin or fixed priority, so hardware-selected multiplexing replaces externally driven select lines. It sits between several producers and a single consumer in the simulator test designs.

## Interface
- N_CH, default 4: number of input channels; must be ≥ 2.
- WIDTH, default 8: data width per channel; must be ≥ 1.
- MODE, default 0: arbitration mode.
  - 0 = round-robin.
  - 1 = fixed priority, with channel 0 highest.
- SEL_W, derived as max(1, clog2(N_CH)); not overridable.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, N_CH: bit i means channel i presents data.
- in_data, input, N_CH*WIDTH: packed bus; channel i occupies [i*WIDTH +: WIDTH].
- in_ready, output, N_CH: one-hot or zero; bit i means channel i's data is accepted this cycle.
- out_valid, output, 1: output register holds a valid word.
- out_data, output, WIDTH: registered data word.
- out_sel, output, SEL_W: index of the channel that supplied out_data.
- out_ready, input, 1: consumer accepts the word this cycle.

## Operation
- **Slot free:** `free = !out_valid || out_ready`.
- **Grant:** computed combinationally every cycle from in_valid, ptr and MODE.
  - MODE 0: the first channel with in_valid set, searching from ptr upward and wrapping from N_CH-1 to 0.
  - MODE 1: the lowest-index channel with in_valid set.
- **in_ready:** `in_ready[g] = free && any(in_valid)`; all other bits are 0. in_ready never asserts for a channel whose in_valid is low.
- **Transfer on input channel i:** occurs when in_valid[i] && in_ready[i]. On the next edge:
  - out_data ← in_data[g], out_sel ← g, out_valid ← 1.
  - ptr ← (g+1) mod N_CH in MODE 0. ptr is unchanged in MODE 1.
- **free and no in_valid:** out_valid ← 0. out_data, out_sel and ptr hold.
- **Stall (!free):** out_valid, out_data, out_sel and ptr hold; in_ready is all zero.
- **Data stability:** out_data and out_sel change only when a new word is loaded.
- **ptr:** internal register, SEL_W bits, range 0..N_CH-1. Wrap-around is explicit for non-power-of-two N_CH; ptr never takes a value ≥ N_CH.
- **Reset:** rst overrides everything, including an in-flight transfer. A word presented in the reset cycle is dropped, and in_ready may be high in that cycle without the word being captured.
- **State summary:** EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY → FULL on any in_valid.
  - FULL → FULL on out_ready with any in_valid.
  - FULL → EMPTY on out_ready with no in_valid.
  - FULL holds on !out_ready.

## Timing
- Reset values after an edge with rst=1:
  - out_valid = 0
  - out_data = 0
  - out_sel = 0
  - ptr = 0
  - in_ready = 0 while out_valid = 0 and in_valid = 0
- **Latency:** 1 cycle from accepted input to out_valid/out_data.
- **Throughput:** 1 word per cycle when out_ready is held high.
- **Combinational paths:** in_ready depends on out_ready, in_valid and registered state within the same cycle. There is no combinational path from in_data to any output.
- **Simultaneous events:**
  - out_ready with a new grant in the same cycle: the old word is consumed and the new word loaded on the same edge, with no bubble.
  - All channels valid: exactly one grant.
- **Fairness (MODE 0):** a channel held valid is granted within N_CH transfers.
- **Producer obligation:** hold in_data stable while in_valid is high and in_ready is low. The block does not check this.

## Test plan
- **Reset:** rst=1 for 2 cycles with all in_valid=1.
  - Required: out_valid=0, out_data=0, out_sel=0 after reset.
  - Required: first grant after release is ch0 in MODE 0.
- **Round-robin (N_CH=4, WIDTH=8, MODE 0):**
  - Stimulus: all valid, in_data = {0x33,0x22,0x11,0x00}, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0 and out_data 0x00,0x11,0x22,0x33,0x00 on consecutive cycles.
- **Backpressure:**
  - Stimulus: out_ready=0 for 3 cycles while FULL with out_data=0x11.
  - Required: out_data holds 0x11 and in_ready=0 throughout; after out_ready=1, the next word loads on the next edge.
- **Sparse RR:**
  - Stimulus: only ch1 and ch3 valid, ptr=2.
  - Required: grant sequence 3,1,3,1.
- **Fixed priority (MODE 1):**
  - Stimulus: ch0 and ch2 valid continuously.
  - Required: ch0 always granted; ch2 granted only after ch0 drops.
- **Non-power-of-two (N_CH=3):**
  - Stimulus: all valid.
  - Required: out_sel sequence 0,1,2,0; ptr never reaches 3.

Source files
------------

// File: rtl/rr_mux_arb.sv
// rr_mux_arb
// N_CH producers compete for a single registered output word. The winner of
// each cycle is chosen in hardware, either round-robin (MODE 0) or by fixed
// priority with channel 0 highest (MODE 1). Both sides use a valid/ready
// handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   [N_CH]        channel i presents a word
//   in_data    [N_CH*WIDTH]  channel i occupies [i*WIDTH +: WIDTH]
//   in_ready   [N_CH]        one-hot or zero; granted channel accepted this cycle
//   out_valid                output register holds a valid word
//   out_data   [WIDTH]       registered data word
//   out_sel    [SEL_W]       channel that supplied out_data
//   out_ready                consumer takes the word this cycle
module rr_mux_arb #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int SEL_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [SEL_W-1:0]   ptr_r;
  logic [SEL_W-1:0]   ptr_nxt_s;
  logic [SEL_W-1:0]   grant_s;
  logic [SEL_W-1:0]   sel_r;
  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   win_data_s;
  logic [SEL_W:0]     idx_s;
  logic               found_s;
  logic               any_s;
  logic               free_s;
  logic               load_s;

  assign any_s     = |in_valid;
  assign free_s    = (state_r == ST_EMPTY) || out_ready;
  assign load_s    = free_s && any_s;
  assign out_valid = (state_r == ST_FULL);
  assign out_data  = data_r;
  assign out_sel   = sel_r;

  // Arbiter: pick the winning channel from in_valid, ptr_r and MODE.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = '0;
    if (MODE == 32'sd1) begin
      // Scan downward so the lowest valid index is the last one written.
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_s = SEL_W'(i);
        end else begin
          grant_s = grant_s;
        end
      end
    end else begin
      // Search from ptr_r upward, wrapping explicitly so non-power-of-two
      // channel counts never index past N_CH-1.
      for (int k = 0; k < N_CH; k++) begin
        idx_s = {1'b0, ptr_r} + (SEL_W + 1)'(k);
        if (idx_s >= (SEL_W + 1)'(N_CH)) begin
          idx_s = idx_s - (SEL_W + 1)'(N_CH);
        end else begin
          idx_s = idx_s;
        end
        if (!found_s && in_valid[idx_s[SEL_W-1:0]]) begin
          grant_s = idx_s[SEL_W-1:0];
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Handshake: only the granted channel sees ready, and only if the slot is free.
  always_comb begin
    in_ready = '0;
    if (load_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Data select: constant-index mux keeps in_data slicing simple.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_s == SEL_W'(i)) begin
        win_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next round-robin pointer: one past the winner, wrapped at N_CH.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (MODE == 32'sd0) begin
      if (grant_s == SEL_W'(N_CH - 1)) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = grant_s + SEL_W'(1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Output-slot FSM next state: EMPTY/FULL tracking of the output register.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (any_s) begin
          state_s = ST_FULL;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_s = any_s ? ST_FULL : ST_EMPTY;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State register for the output-slot FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Output word, source index and pointer: updated only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
      sel_r  <= '0;
      ptr_r  <= '0;
    end else if (load_s) begin
      data_r <= win_data_s;
      sel_r  <= grant_s;
      ptr_r  <= ptr_nxt_s;
    end else begin
      data_r <= data_r;
      sel_r  <= sel_r;
      ptr_r  <= ptr_r;
    end
  end

endmodule
